// File: rtl/dp_ram_ctrl.sv
// dp_ram_ctrl: simple dual-port RAM with clear sweep, selectable read latency and read-during-write mode
module dp_ram_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE = 0,
   parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  wr_drop
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   typedef enum logic {SWEEP, RUN} state_t;
   state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  wr_user, rd_req, mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din, rd_data;
   logic                  s1_valid, out_valid;
   logic [DATA_WIDTH-1:0] s1_data, out_data;
   // state and sweep pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SWEEP;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end
   // next state, sweep/user port arbitration and read-during-write selection
   always_comb begin
      busy      = state == SWEEP;
      wr_user   = state == RUN && !clear && we;
      rd_req    = state == RUN && !clear && re;
      mem_we    = !rst && (busy || wr_user);
      mem_addr  = busy ? ptr : write_addr;
      mem_din   = busy ? FILL_VALUE : data_in;
      rd_data   = (RDW_MODE == 1 && wr_user && write_addr == read_addr) ? data_in : mem[read_addr];
      state_nxt = clear ? SWEEP : (busy && ptr == '1) ? RUN : state;
      ptr_nxt   = (clear || !busy) ? '0 : ptr + 1'b1;
   end
   // storage array; a read in the same edge sees the pre-write word
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_din;
   end
   // optional intermediate read stage used when RD_LATENCY is 2
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= rd_req;
         if (rd_req) s1_data <= rd_data;
      end
   end
   assign out_valid = RD_LATENCY == 2 ? s1_valid : rd_req;
   assign out_data  = RD_LATENCY == 2 ? s1_data : rd_data;
   // output register: data held between reads, valid pulses once per result
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= out_valid;
         if (out_valid) data_out <= out_data;
      end
   end
   // sticky flag for writes requested while the sweep owns the array
   always_ff @(posedge clk) begin
      if (rst) wr_drop <= 1'b0;
      else if (we && (busy || clear)) wr_drop <= 1'b1;
   end
endmodule

// File: tb/tb_dp_ram_ctrl.sv
// tb_dp_ram_ctrl: randomized and directed checks of two dp_ram_ctrl configurations against a behavioural model
module tb_dp_ram_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;
   localparam logic [DW-1:0] FILL = 8'hA5;
   logic          clk = 1'b0;
   logic          rst = 1'b1, clear = 1'b0, we = 1'b0, re = 1'b0;
   logic [AW-1:0] write_addr = '0, read_addr = '0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out_a, data_out_b;
   logic          rd_valid_a, rd_valid_b, busy_a, busy_b, wr_drop_a, wr_drop_b;
   int            checks = 0, errors = 0;
   // behavioural model state
   int            sweep_left = DEPTH;
   logic [DW-1:0] mem_m [DEPTH];
   logic          m_drop = 1'b0;
   logic          ea_v = 1'b0, eb_v = 1'b0, pb_v = 1'b0;
   logic [DW-1:0] ea_d = '0, eb_d = '0, pb_d = '0;
   // latency 1, old-data read-during-write
   dp_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0), .FILL_VALUE(FILL)) u_a (
      .clk(clk), .rst(rst), .clear(clear), .we(we), .write_addr(write_addr), .data_in(data_in),
      .re(re), .read_addr(read_addr), .data_out(data_out_a), .rd_valid(rd_valid_a),
      .busy(busy_a), .wr_drop(wr_drop_a));
   // latency 2, new-data read-during-write
   dp_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1), .FILL_VALUE(FILL)) u_b (
      .clk(clk), .rst(rst), .clear(clear), .we(we), .write_addr(write_addr), .data_in(data_in),
      .re(re), .read_addr(read_addr), .data_out(data_out_b), .rd_valid(rd_valid_b),
      .busy(busy_b), .wr_drop(wr_drop_b));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask
   // one clock edge: advance the model with the held inputs, then compare all outputs
   task automatic tick();
      logic [DW-1:0] old;
      logic          busy_m, iss, wr;
      @(posedge clk);
      if (rst) begin
         sweep_left = DEPTH;
         m_drop = 1'b0;
         ea_v = 1'b0; ea_d = '0;
         eb_v = 1'b0; eb_d = '0;
         pb_v = 1'b0; pb_d = '0;
      end else begin
         busy_m = sweep_left > 0;
         iss = !busy_m && !clear && re;
         wr = !busy_m && !clear && we;
         if (we && (busy_m || clear)) m_drop = 1'b1;
         old = mem_m[read_addr];
         eb_v = pb_v;
         if (pb_v) eb_d = pb_d;
         pb_v = iss;
         pb_d = (wr && write_addr == read_addr) ? data_in : old;
         ea_v = iss;
         if (iss) ea_d = old;
         if (wr) mem_m[write_addr] = data_in;
         if (busy_m) begin
            mem_m[DEPTH - sweep_left] = FILL;
            sweep_left--;
         end
         if (clear) sweep_left = DEPTH;
      end
      #1;
      check("busy_a", busy_a, sweep_left > 0);
      check("busy_b", busy_b, sweep_left > 0);
      check("wr_drop_a", wr_drop_a, m_drop);
      check("wr_drop_b", wr_drop_b, m_drop);
      check("rd_valid_a", rd_valid_a, ea_v);
      check("rd_valid_b", rd_valid_b, eb_v);
      check("data_out_a", data_out_a, ea_d);
      check("data_out_b", data_out_b, eb_d);
   endtask
   task automatic drive(input logic r, input logic c, input logic w, input logic [AW-1:0] wa,
                        input logic [DW-1:0] d, input logic rr, input logic [AW-1:0] ra);
      rst = r; clear = c; we = w; write_addr = wa; data_in = d; re = rr; read_addr = ra;
      tick();
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic wait_sweep();
      for (int i = 0; i < 2 * DEPTH && sweep_left > 0; i++) idle(1);
   endtask
   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      wait_sweep();
      for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 0, 1, AW'(i));
      idle(3);
      drive(0, 0, 1, 5, 8'h3C, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 5);
      idle(3);
      drive(0, 0, 1, 7, 8'h11, 0, 0);
      drive(0, 0, 1, 7, 8'h22, 1, 7);
      idle(2);
      drive(0, 0, 0, 0, 0, 1, 7);
      idle(3);
      drive(0, 0, 1, 3, 8'h55, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 3, 8'h77, 0, 0);
      wait_sweep();
      drive(0, 0, 0, 0, 0, 1, 3);
      drive(0, 0, 1, 9, 8'h9E, 1, 3);
      drive(0, 1, 1, 9, 8'h44, 1, 9);
      drive(0, 0, 0, 0, 0, 0, 0);
      wait_sweep();
      drive(0, 0, 0, 0, 0, 1, 9);
      drive(0, 1, 0, 0, 0, 0, 0);
      idle(6);
      drive(1, 0, 1, 2, 8'h01, 1, 2);
      wait_sweep();
      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0] wa;
         wa = AW'($urandom_range(0, DEPTH - 1));
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), wa,
               DW'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0 ? wa : AW'($urandom_range(0, DEPTH - 1)));
      end
      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
